// File: rtl/sensor_round_sequencer.sv
// sensor_round_sequencer
// Autonomous sequencer for sensor_ctrl. It arms the sensor, waits for buffer-full,
// drains N words onto a valid/ready stream, pulses clear and optionally rests for a
// programmed number of cycles before starting the next round.
module sensor_round_sequencer #(
  parameter int DEPTH    = 64,
  parameter int PERIOD_W = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     cfg_start,
  input  logic                     cfg_stop,
  input  logic [6:0]               cfg_count,
  input  logic [PERIOD_W-1:0]      cfg_period,
  output logic                     sctrl_en,
  output logic                     sctrl_clear,
  output logic [$clog2(DEPTH)-1:0] sctrl_addr,
  input  logic                     sctrl_interrupt,
  input  logic [31:0]              sctrl_out,
  output logic                     m_valid,
  output logic [31:0]              m_data,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic                     busy,
  output logic                     round_done,
  output logic [15:0]              round_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 7;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READ,
    CLEAR,
    WAIT
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       n_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] wait_q;
  logic [AW-1:0]       addr_q;
  logic                stop_q;
  logic                abort_q;
  logic [15:0]         round_cnt_q;

  logic                stop_any;
  logic                beat_last;
  logic [CW-1:0]       n_eff;

  // A stop request counts whether it arrives this cycle or was latched earlier.
  assign stop_any  = cfg_stop | stop_q;
  assign beat_last = (CW'(addr_q) == (n_q - CW'(1)));
  assign n_eff     = ((cfg_count == '0) || (cfg_count > CW'(DEPTH))) ? CW'(DEPTH) : cfg_count;
  assign round_cnt = round_cnt_q;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a stop in ARM or WAIT takes priority over other events.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) state_d = ARM;
      end
      ARM: begin
        if (stop_any)             state_d = CLEAR;
        else if (sctrl_interrupt) state_d = READ;
      end
      READ: begin
        if (m_ready && beat_last) state_d = CLEAR;
      end
      CLEAR: begin
        if (stop_any || (period_q == '0)) state_d = IDLE;
        else                              state_d = WAIT;
      end
      WAIT: begin
        if (stop_any)                          state_d = CLEAR;
        else if (wait_q <= PERIOD_W'(1))       state_d = ARM;
      end
      default: state_d = IDLE;
    endcase
  end

  // Round bookkeeping: latched config, read address, rest counter, stop/abort flags, round count.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      n_q         <= '0;
      period_q    <= '0;
      wait_q      <= '0;
      addr_q      <= '0;
      stop_q      <= 1'b0;
      abort_q     <= 1'b0;
      round_cnt_q <= '0;
    end else begin
      if ((state_q == IDLE) && cfg_start) begin
        n_q         <= n_eff;
        period_q    <= cfg_period;
        round_cnt_q <= '0;
      end

      if ((state_q == CLEAR) && (state_d == IDLE)) begin
        stop_q <= 1'b0;
      end else if ((state_q != IDLE) && cfg_stop) begin
        stop_q <= 1'b1;
      end

      if ((state_q == ARM) && (state_d == READ)) begin
        addr_q <= '0;
      end else if ((state_q == READ) && m_ready) begin
        addr_q <= addr_q + AW'(1);
      end

      if ((state_d == CLEAR) && (state_q != CLEAR)) begin
        abort_q <= (state_q != READ);
      end

      if ((state_q == CLEAR) && !abort_q) begin
        round_cnt_q <= round_cnt_q + 16'd1;
      end

      if ((state_q == CLEAR) && (state_d == WAIT)) begin
        wait_q <= period_q;
      end else if (state_q == WAIT) begin
        wait_q <= wait_q - PERIOD_W'(1);
      end
    end
  end

  // Output decode from the registered state; the stream is only driven while draining.
  always_comb begin
    sctrl_en    = 1'b0;
    sctrl_clear = 1'b0;
    sctrl_addr  = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    busy        = (state_q != IDLE);
    round_done  = 1'b0;
    case (state_q)
      ARM: begin
        sctrl_en = 1'b1;
      end
      READ: begin
        sctrl_addr = addr_q;
        m_valid    = 1'b1;
        m_data     = sctrl_out;
        m_last     = beat_last;
      end
      CLEAR: begin
        sctrl_clear = 1'b1;
        round_done  = !abort_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sensor_round_sequencer.sv
// tb_sensor_round_sequencer
// Drives directed scenarios and a randomized run, comparing every cycle against a
// round-level behavioural model, plus literal expectations for the key scenarios.
module tb_sensor_round_sequencer;

  localparam int DEPTH = 64;
  localparam int PW    = 16;

  localparam int PH_QUIET = 0;
  localparam int PH_ARMED = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_CLEAR = 3;
  localparam int PH_REST  = 4;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [6:0]    cfg_count = '0;
  logic [PW-1:0] cfg_period = '0;
  logic          sctrl_en;
  logic          sctrl_clear;
  logic [5:0]    sctrl_addr;
  logic          sctrl_interrupt = 1'b0;
  logic [31:0]   sctrl_out;
  logic          m_valid;
  logic [31:0]   m_data;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          round_done;
  logic [15:0]   round_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  logic [31:0] salt = 32'h0;

  // Round-level model of what the sequencer must be doing.
  int mph = PH_QUIET;
  int mn = 0;
  int mp = 0;
  int mbeat = 0;
  int mwait = 0;
  int mrounds = 0;
  bit mstop = 0;
  bit mabort = 0;

  // Observations of the DUT used for literal scenario expectations.
  int beats_seen, last_addr, done_seen, clear_seen, clear_cyc, last_gap;
  bit prev_en = 0;

  sensor_round_sequencer #(.DEPTH(DEPTH), .PERIOD_W(PW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_count(cfg_count), .cfg_period(cfg_period),
    .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear), .sctrl_addr(sctrl_addr),
    .sctrl_interrupt(sctrl_interrupt), .sctrl_out(sctrl_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .round_done(round_done), .round_cnt(round_cnt)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] sens_word(input int a, input logic [31:0] s);
    logic [7:0] b;
    b = 8'(a);
    return s ^ {8'h5A, b, 8'(b * 8'd3), ~b};
  endfunction

  // Sensor buffer read port: combinational from the address.
  always_comb sctrl_out = sens_word(int'(sctrl_addr), salt);

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic resetStats();
    beats_seen = 0; last_addr = -1; done_seen = 0; clear_seen = 0;
    clear_cyc = -1; last_gap = -1;
  endtask

  task automatic modelReset();
    mph = PH_QUIET; mn = 0; mp = 0; mbeat = 0; mwait = 0;
    mrounds = 0; mstop = 0; mabort = 0;
  endtask

  task automatic checkOutput();
    logic [31:0] e_data;
    e_data = (mph == PH_DRAIN) ? sens_word(mbeat, salt) : 32'h0;
    checkVal("sctrl_en",    32'(sctrl_en),    32'(mph == PH_ARMED));
    checkVal("sctrl_clear", 32'(sctrl_clear), 32'(mph == PH_CLEAR));
    checkVal("round_done",  32'(round_done),  32'(mph == PH_CLEAR && !mabort));
    checkVal("busy",        32'(busy),        32'(mph != PH_QUIET));
    checkVal("m_valid",     32'(m_valid),     32'(mph == PH_DRAIN));
    checkVal("sctrl_addr",  32'(sctrl_addr),  (mph == PH_DRAIN) ? 32'(mbeat) : 32'h0);
    checkVal("m_data",      m_data,           e_data);
    checkVal("m_last",      32'(m_last),      32'(mph == PH_DRAIN && mbeat == mn - 1));
    checkVal("round_cnt",   32'(round_cnt),   32'(mrounds));
  endtask

  task automatic observe();
    if (sctrl_clear) begin
      clear_seen++;
      clear_cyc = cycle;
    end
    if (round_done) done_seen++;
    if (sctrl_en && !prev_en && clear_cyc >= 0) last_gap = cycle - clear_cyc;
    prev_en = sctrl_en;
    if (m_valid && m_ready) begin
      beats_seen++;
      if (m_last) last_addr = int'(sctrl_addr);
    end
  endtask

  task automatic modelStep(input bit st, input bit sp, input bit irq, input bit rdy);
    case (mph)
      PH_QUIET: if (st) begin
        mn = (cfg_count == 0 || int'(cfg_count) > DEPTH) ? DEPTH : int'(cfg_count);
        mp = int'(cfg_period);
        mrounds = 0;
        mstop = 0;
        mph = PH_ARMED;
      end
      PH_ARMED: if (sp) begin
        mstop = 1; mabort = 1; mph = PH_CLEAR;
      end else if (irq) begin
        mbeat = 0; mph = PH_DRAIN;
      end
      PH_DRAIN: begin
        if (sp) mstop = 1;
        if (rdy) begin
          if (mbeat == mn - 1) begin
            mabort = 0; mph = PH_CLEAR;
          end else begin
            mbeat++;
          end
        end
      end
      PH_CLEAR: begin
        if (!mabort) mrounds = (mrounds + 1) % 65536;
        if (mstop || sp || mp == 0) begin
          mstop = 0; mph = PH_QUIET;
        end else begin
          mwait = mp; mph = PH_REST;
        end
      end
      default: if (sp) begin
        mstop = 1; mabort = 1; mph = PH_CLEAR;
      end else if (mwait == 1) begin
        mph = PH_ARMED;
      end else begin
        mwait--;
      end
    endcase
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit st, input bit sp, input bit irq, input bit rdy);
    @(negedge ACLK);
    cfg_start = st; cfg_stop = sp; sctrl_interrupt = irq; m_ready = rdy;
    cycle++;
    #1;
    checkOutput();
    observe();
    modelStep(st, sp, irq, rdy);
  endtask

  task automatic runToPhase(input int target, input bit irq, input bit rdy, input int budget);
    int n;
    n = 0;
    while (mph != target && n < budget) begin
      applyStimulus(0, 0, irq, rdy);
      n++;
    end
    if (mph != target) begin
      miscompares++;
      $display("[TB] FAIL timeout waiting for phase: got %0d, expected %0d", mph, target);
    end
  endtask

  task automatic doReset();
    cfg_start = 0; cfg_stop = 0; sctrl_interrupt = 0; m_ready = 0;
    ARESETn = 0;
    modelReset();
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
  endtask

  initial begin
    int n;
    resetStats();
    doReset();
    salt = 32'h1234_0000;

    // Scenario 1: one-shot round, N=4, interrupt on the third ARM cycle.
    resetStats();
    cfg_count = 7'd4; cfg_period = '0;
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    runToPhase(PH_QUIET, 0, 1, 20);
    applyStimulus(0, 0, 0, 1);
    checkVal("s1_beats", 32'(beats_seen), 32'd4);
    checkVal("s1_last_addr", 32'(last_addr), 32'd3);
    checkVal("s1_done", 32'(done_seen), 32'd1);
    checkVal("s1_round_cnt", 32'(round_cnt), 32'd1);
    checkVal("s1_busy", 32'(busy), 32'd0);

    // Scenario 2: backpressure with ready pattern 1,0,0,1,0,0,...
    resetStats();
    salt = 32'hBEEF_0101;
    cfg_count = 7'd3;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    n = 0;
    while (mph != PH_QUIET && n < 40) begin
      applyStimulus(0, 0, 0, (n % 3) == 0);
      n++;
    end
    checkVal("s2_beats", 32'(beats_seen), 32'd3);
    checkVal("s2_last_addr", 32'(last_addr), 32'd2);

    // Scenario 3: periodic N=2, P=5 for three rounds.
    resetStats();
    cfg_count = 7'd2; cfg_period = 16'd5;
    applyStimulus(1, 0, 0, 1);
    n = 0;
    while (mrounds < 3 && n < 60) begin
      applyStimulus(0, 0, 1, 1);
      n++;
    end
    checkVal("s3_done", 32'(done_seen), 32'd3);
    checkVal("s3_gap", 32'(last_gap), 32'd6);

    // Scenario 4a: stop while resting between rounds.
    applyStimulus(0, 1, 0, 1);
    runToPhase(PH_QUIET, 0, 1, 10);
    applyStimulus(0, 0, 0, 1);
    checkVal("s4_done_after_stop", 32'(done_seen), 32'd3);
    checkVal("s4_clears", 32'(clear_seen), 32'd4);
    checkVal("s4_round_cnt", 32'(round_cnt), 32'd3);

    // Scenario 4b: stop during a stalled read; the round still completes.
    resetStats();
    cfg_count = 7'd3; cfg_period = 16'd10;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    runToPhase(PH_QUIET, 0, 1, 30);
    applyStimulus(0, 0, 0, 1);
    checkVal("s4b_beats", 32'(beats_seen), 32'd3);
    checkVal("s4b_done", 32'(done_seen), 32'd1);
    checkVal("s4b_round_cnt", 32'(round_cnt), 32'd1);

    // Scenario 5: count of 0 means a full buffer.
    resetStats();
    cfg_count = 7'd0; cfg_period = '0;
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    runToPhase(PH_QUIET, 0, 1, 100);
    checkVal("s5_beats", 32'(beats_seen), 32'd64);
    checkVal("s5_last_addr", 32'(last_addr), 32'd63);

    // Scenario 6: asynchronous reset in the middle of a read.
    cfg_count = 7'd8; cfg_period = 16'd3;
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    @(posedge ACLK);
    #3;
    ARESETn = 0;
    #1;
    checkVal("s6_busy", 32'(busy), 32'd0);
    checkVal("s6_m_valid", 32'(m_valid), 32'd0);
    checkVal("s6_addr", 32'(sctrl_addr), 32'd0);
    checkVal("s6_m_data", m_data, 32'd0);
    checkVal("s6_clear", 32'(sctrl_clear), 32'd0);
    checkVal("s6_en", 32'(sctrl_en), 32'd0);
    doReset();
    resetStats();
    cfg_count = 7'd5; cfg_period = '0;
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 1, 1);
    runToPhase(PH_QUIET, 0, 1, 20);
    checkVal("s6_restart_beats", 32'(beats_seen), 32'd5);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      bit st, sp, irq, rdy;
      if (mph == PH_QUIET && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0: cfg_count = 7'd0;
          1: cfg_count = 7'd1;
          2: cfg_count = 7'd64;
          3: cfg_count = 7'd65 + 7'($urandom_range(0, 62));
          default: cfg_count = 7'($urandom_range(1, 12));
        endcase
        cfg_period = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 7));
        salt = $urandom;
      end
      st  = ($urandom_range(0, 19) == 0);
      sp  = ($urandom_range(0, 59) == 0);
      irq = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(st, sp, irq, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
